lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store sequencing stage between the execute stage and the data memory.
- Accepts one memory request at a time over a valid/ready handshake and checks alignment and funct3 legality.
- Drives the memory with the correct timing: data memory has a one-cycle registered read, and stores need that read first for byte/half merge.
- Returns the load result or a fault to writeback over a second valid/ready handshake.

Parameters:
- ADDRESS_WIDTH, 32, width of request and memory address
- DATA_WIDTH, 32, data width
- TAG_WIDTH, 5, destination-register tag carried from request to response

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  stage can accept (high only in IDLE)
- req_is_store  input  1  1 = store, 0 = load
- req_funct3  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  input  ADDRESS_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data
- req_tag  input  TAG_WIDTH  rd tag
- flush  input  1  abort in-flight load
- mem_address  output  ADDRESS_WIDTH  to data memory
- mem_write_data  output  DATA_WIDTH  to data memory
- mem_control  output  3  funct3 to data memory
- mem_write_enable  output  1  to data memory
- mem_read_data  input  DATA_WIDTH  formatted read data, valid one cycle after address is presented
- resp_valid  output  1  response present
- resp_ready  input  1  writeback accepts
- resp_rdata  output  DATA_WIDTH  load result, 0 for stores and faults
- resp_tag  output  TAG_WIDTH  tag of the completed request
- resp_fault  output  1  misaligned or illegal access

Behaviour:
- States: IDLE, ADDR, DATA (loads only), WRITE (stores only), RESP.
- Reset (rst_n low, asynchronous): state IDLE. The registers addr, wdata, funct3, tag, is_store, resp_rdata and resp_fault all clear to 0.
- Outputs after reset: req_ready=1, resp_valid=0, mem_write_enable=0, mem_address=0, mem_control=000.
- Accept: at a rising edge with state IDLE and req_valid=1, capture all req_* fields. req_ready = (state==IDLE).
- Fault check at accept:
  - half access (001/101) with addr[0]=1 is a fault.
  - word access (010) with addr[1:0]!=00 is a fault.
  - funct3 in {011, 110, 111} is a fault.
  - a store with funct3 100 or 101 is a fault.
- Fault path: IDLE->RESP directly, resp_fault=1, resp_rdata=0. No memory access; mem_write_enable is never asserted.
- Memory outputs:
  - mem_address, mem_write_data and mem_control are driven from the captured registers in every state.
  - mem_write_enable = (state==WRITE); it is combinational from state only.
- Load sequence: ADDR (memory samples the address) -> DATA. The edge leaving DATA captures mem_read_data into resp_rdata, then the FSM enters RESP.
  - resp_valid rises 3 cycles after the accept edge.
- Store sequence: ADDR (memory fetches the old word) -> WRITE (one cycle, mem_write_enable=1) -> RESP with resp_rdata=0.
  - Exactly one write-enable cycle per store.
- RESP: resp_valid=1. resp_tag, resp_rdata and resp_fault stay stable until an edge with resp_ready=1, then IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- flush:
  - In ADDR or DATA of a load: go to IDLE at the next edge with no response.
  - Ignored for stores in any state, and ignored in RESP and IDLE.
- Reset mid-operation: the FSM drops to IDLE immediately, with no partial write. mem_write_enable falls asynchronously with rst_n.
- Width: mem_address equals the full byte address; the memory performs word indexing and lane selection.

Test Plan:
- sw addr 0x00001000 data 0xDEADBEEF -> mem_write_enable high for exactly 1 cycle, 2 cycles after accept; resp_valid with fault=0, rdata=0. Then lw 0x1000 -> resp_rdata=0xDEADBEEF, resp_valid 3 cycles after accept, resp_tag echoed.
- After the above, sb 0x1001 data 0x000000A5 -> lw 0x1000 returns 0xDEADA5EF; lb 0x1001 returns 0xFFFFFFA5; lbu 0x1001 returns 0x000000A5.
- lw 0x1002, lh 0x1003, sb with funct3=100, and lw with funct3=011 -> each gives resp_fault=1, rdata=0, response 1 cycle after accept, mem_write_enable never high.
- Load with resp_ready held low for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout; a request presented during this time is not accepted until 1 cycle after the response handshake.
- Load with flush in ADDR -> no resp_valid, req_ready=1 next cycle. Store with flush in ADDR -> write still occurs and the response is returned.
- rst_n pulsed low during WRITE of sw 0x2000 0x12345678 -> mem_write_enable drops immediately. After release, lw 0x2000 returns the pre-store contents; state is IDLE with resp_valid=0.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store sequencing stage: accepts one request, checks alignment and funct3,
// sequences the registered-read data memory and returns a load result or fault.
module lsu_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_is_store,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [TAG_WIDTH-1:0]     req_tag,
  input  logic                     flush,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic [2:0]               mem_control,
  output logic                     mem_write_enable,
  input  logic [DATA_WIDTH-1:0]    mem_read_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic [TAG_WIDTH-1:0]     resp_tag,
  output logic                     resp_fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [TAG_WIDTH-1:0]     tag_q, tag_d;
  logic                     is_store_q, is_store_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     fault_q, fault_d;
  logic                     accept_fault_s;

  // Unsigned loads only exist for byte/half; 011/110/111 are reserved encodings.
  function automatic logic access_fault(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] lsb);
    logic f;
    case (f3)
      3'b000:  f = 1'b0;
      3'b001:  f = lsb[0];
      3'b010:  f = (lsb != 2'b00);
      3'b100:  f = is_store;
      3'b101:  f = is_store | lsb[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  assign accept_fault_s = access_fault(req_is_store, req_funct3, req_addr[1:0]);

  // Next-state and captured-field update.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    tag_d      = tag_q;
    is_store_d = is_store_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          funct3_d   = req_funct3;
          tag_d      = req_tag;
          is_store_d = req_is_store;
          rdata_d    = '0;
          fault_d    = accept_fault_s;
          state_d    = accept_fault_s ? S_RESP : S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (is_store_q) begin
          state_d = S_WRITE;
        end else if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rdata_d = mem_read_data;
          state_d = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= 3'b000;
      tag_q      <= '0;
      is_store_q <= 1'b0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      tag_q      <= tag_d;
      is_store_q <= is_store_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
    end
  end

  assign req_ready        = (state_q == S_IDLE);
  assign resp_valid       = (state_q == S_RESP);
  assign mem_write_enable = (state_q == S_WRITE);
  assign mem_address      = addr_q;
  assign mem_write_data   = wdata_q;
  assign mem_control      = funct3_q;
  assign resp_rdata       = rdata_q;
  assign resp_tag         = tag_q;
  assign resp_fault       = fault_q;

endmodule
